// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Moore-style main control FSM for a multicycle MIPS-like
//                datapath. Sequences fetch, decode, execute, memory and
//                write-back steps and drives the datapath control strobes.
//                An optional memory handshake stretches FETCH, MEMRD and
//                MEMWR until mem_ready. Unknown opcodes or unused state codes
//                park the FSM in HALT, which only reset can leave.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                opcode     - instr[31:26] from the instruction register
//                mem_ready  - memory access completes this cycle
//                pcwrite, branch, branch_ne, iord, memwrite, irwrite,
//                regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc
//                           - datapath control strobes
//                illegal    - FSM is in HALT
//                retire     - last cycle of an instruction
//                state      - current state code (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_HANDSHAKE = 0,
    parameter int ENABLE_BNE    = 1,
    parameter int ENABLE_ADDI   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       illegal,
    output logic       retire,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_BNEEX   = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_HALT    = 4'd15;

    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    localparam logic C_HS_EN   = (MEM_HANDSHAKE != 0);
    localparam logic C_BNE_EN  = (ENABLE_BNE != 0);
    localparam logic C_ADDI_EN = (ENABLE_ADDI != 0);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_ready;

    // Without the handshake every memory access is treated as single-cycle.
    assign w_ready = C_HS_EN ? mem_ready : 1'b1;
    assign state   = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_HALT;
        case (r_state)
            S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    C_OP_RTYPE:      w_next = S_RTYPEEX;
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_BEQ:        w_next = S_BEQEX;
                    C_OP_BNE:        w_next = C_BNE_EN  ? S_BNEEX  : S_HALT;
                    C_OP_ADDI:       w_next = C_ADDI_EN ? S_ADDIEX : S_HALT;
                    C_OP_J:          w_next = S_JEX;
                    default:         w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                // The IR is stable here, but guard against anything that is
                // neither a load nor a store reaching this state.
                if (opcode == C_OP_LW) begin
                    w_next = S_MEMRD;
                end else if (opcode == C_OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQEX, S_BNEEX, S_ADDIWB, S_JEX:
                       w_next = S_FETCH;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_HALT;
        endcase
    end

    always_comb begin
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        pcsrc     = 2'b00;
        case (r_state)
            S_FETCH: begin
                // Qualified by rst_n so the PC/IR are not written while reset
                // holds the FSM in FETCH, and by w_ready so a stalled fetch
                // increments the PC only once.
                alusrcb = 2'b01;
                irwrite = w_ready & rst_n;
                pcwrite = w_ready & rst_n;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                // memwrite stays up through the whole stall; the instruction
                // only retires in the cycle the memory accepts the write.
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = w_ready;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
                retire    = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
            end
            S_HALT: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Three instances
//                share clock, reset and opcode: default parameters, memory
//                handshake enabled, and bne/addi disabled. A vector table
//                walks every instruction class on the default instance;
//                hand-written sequences cover stalls, illegal opcodes and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    // Expected-output word layout:
    // state[3:0] _ pcwrite irwrite iord memwrite _ regdst memtoreg regwrite
    // alusrca _ alusrcb aluop pcsrc _ branch branch_ne illegal retire
    localparam logic [21:0] V_RST    = 22'b0000_0000_0000_010000_0000;
    localparam logic [21:0] V_FETCH  = 22'b0000_1100_0000_010000_0000;
    localparam logic [21:0] V_DECODE = 22'b0001_0000_0000_110000_0000;
    localparam logic [21:0] V_MEMADR = 22'b0010_0000_0001_100000_0000;
    localparam logic [21:0] V_MEMRD  = 22'b0011_0010_0000_000000_0000;
    localparam logic [21:0] V_MEMWB  = 22'b0100_0000_0110_000000_0001;
    localparam logic [21:0] V_MEMWR  = 22'b0101_0011_0000_000000_0001;
    localparam logic [21:0] V_MWSTL  = 22'b0101_0011_0000_000000_0000;
    localparam logic [21:0] V_RTYPE  = 22'b0110_0000_0001_001000_0000;
    localparam logic [21:0] V_ALUWB  = 22'b0111_0000_1010_000000_0001;
    localparam logic [21:0] V_BEQEX  = 22'b1000_0000_0001_000101_1001;
    localparam logic [21:0] V_BNEEX  = 22'b1001_0000_0001_000101_0101;
    localparam logic [21:0] V_ADDIEX = 22'b1010_0000_0001_100000_0000;
    localparam logic [21:0] V_ADDIWB = 22'b1011_0000_0010_000000_0001;
    localparam logic [21:0] V_JEX    = 22'b1100_1000_0000_000010_0001;
    localparam logic [21:0] V_HALT   = 22'b1111_0000_0000_000000_0010;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic [21:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    logic [2:0] pcwrite, branch, branch_ne, iord, memwrite, irwrite;
    logic [2:0] regdst, memtoreg, regwrite, alusrca, illegal, retire;
    logic [1:0] alusrcb [3];
    logic [1:0] aluop   [3];
    logic [1:0] pcsrc   [3];
    logic [3:0] st      [3];
    logic [21:0] v      [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_HANDSHAKE(0), .ENABLE_BNE(1), .ENABLE_ADDI(1)) u_dut_def (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite[0]), .branch(branch[0]), .branch_ne(branch_ne[0]),
        .iord(iord[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]),
        .regdst(regdst[0]), .memtoreg(memtoreg[0]), .regwrite(regwrite[0]),
        .alusrca(alusrca[0]), .illegal(illegal[0]), .retire(retire[0]),
        .alusrcb(alusrcb[0]), .aluop(aluop[0]), .pcsrc(pcsrc[0]), .state(st[0])
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1), .ENABLE_BNE(1), .ENABLE_ADDI(1)) u_dut_hs (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite[1]), .branch(branch[1]), .branch_ne(branch_ne[1]),
        .iord(iord[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]),
        .regdst(regdst[1]), .memtoreg(memtoreg[1]), .regwrite(regwrite[1]),
        .alusrca(alusrca[1]), .illegal(illegal[1]), .retire(retire[1]),
        .alusrcb(alusrcb[1]), .aluop(aluop[1]), .pcsrc(pcsrc[1]), .state(st[1])
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(0), .ENABLE_BNE(0), .ENABLE_ADDI(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite[2]), .branch(branch[2]), .branch_ne(branch_ne[2]),
        .iord(iord[2]), .memwrite(memwrite[2]), .irwrite(irwrite[2]),
        .regdst(regdst[2]), .memtoreg(memtoreg[2]), .regwrite(regwrite[2]),
        .alusrca(alusrca[2]), .illegal(illegal[2]), .retire(retire[2]),
        .alusrcb(alusrcb[2]), .aluop(aluop[2]), .pcsrc(pcsrc[2]), .state(st[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_pack
        assign v[k] = {st[k], pcwrite[k], irwrite[k], iord[k], memwrite[k],
                       regdst[k], memtoreg[k], regwrite[k], alusrca[k],
                       alusrcb[k], aluop[k], pcsrc[k],
                       branch[k], branch_ne[k], illegal[k], retire[k]};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset for a full clock edge, check the in-reset outputs, then
    // release away from the active edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_def", {10'd0, v[0]}, {10'd0, V_RST});
        chk("reset_hs",  {10'd0, v[1]}, {10'd0, V_RST});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        int pw_cnt;
        int mw_cnt;
        int rt_cnt;

        tbl.push_back('{OP_LW,   V_FETCH});
        tbl.push_back('{OP_LW,   V_DECODE});
        tbl.push_back('{OP_LW,   V_MEMADR});
        tbl.push_back('{OP_LW,   V_MEMRD});
        tbl.push_back('{OP_LW,   V_MEMWB});
        tbl.push_back('{OP_SW,   V_FETCH});
        tbl.push_back('{OP_SW,   V_DECODE});
        tbl.push_back('{OP_SW,   V_MEMADR});
        tbl.push_back('{OP_SW,   V_MEMWR});
        tbl.push_back('{OP_R,    V_FETCH});
        tbl.push_back('{OP_R,    V_DECODE});
        tbl.push_back('{OP_R,    V_RTYPE});
        tbl.push_back('{OP_R,    V_ALUWB});
        tbl.push_back('{OP_ADDI, V_FETCH});
        tbl.push_back('{OP_ADDI, V_DECODE});
        tbl.push_back('{OP_ADDI, V_ADDIEX});
        tbl.push_back('{OP_ADDI, V_ADDIWB});
        tbl.push_back('{OP_BEQ,  V_FETCH});
        tbl.push_back('{OP_BEQ,  V_DECODE});
        tbl.push_back('{OP_BEQ,  V_BEQEX});
        tbl.push_back('{OP_BNE,  V_FETCH});
        tbl.push_back('{OP_BNE,  V_DECODE});
        tbl.push_back('{OP_BNE,  V_BNEEX});
        tbl.push_back('{OP_J,    V_FETCH});
        tbl.push_back('{OP_J,    V_DECODE});
        tbl.push_back('{OP_J,    V_JEX});
        tbl.push_back('{OP_BAD,  V_FETCH});
        tbl.push_back('{OP_BAD,  V_DECODE});
        tbl.push_back('{OP_BAD,  V_HALT});
        tbl.push_back('{OP_BAD,  V_HALT});

        // ---- Table: every instruction class back to back, no handshake ----
        mem_ready = 1'b1;
        opcode    = OP_LW;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op;
            chk($sformatf("tbl[%0d]", i), {10'd0, v[0]}, {10'd0, tbl[i].exp});
            step();
        end

        // ---- Fetch stalled two cycles on the handshake instance ----
        mem_ready = 1'b0;
        opcode    = OP_R;
        do_reset();
        pw_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("hs_fetch_stall%0d", c), {10'd0, v[1]}, {10'd0, V_RST});
            pw_cnt += int'(pcwrite[1]);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("hs_fetch_ready", {10'd0, v[1]}, {10'd0, V_FETCH});
        pw_cnt += int'(pcwrite[1]);
        step();
        mem_ready = 1'b0;
        #1;
        chk("hs_fetch_decode", {10'd0, v[1]}, {10'd0, V_DECODE});
        pw_cnt += int'(pcwrite[1]);
        chk("hs_fetch_pcwrite_count", pw_cnt, 1);

        // ---- Store stalled three cycles in MEMWR ----
        mem_ready = 1'b1;
        opcode    = OP_SW;
        do_reset();
        step();
        chk("hs_sw_decode", {10'd0, v[1]}, {10'd0, V_DECODE});
        step();
        chk("hs_sw_memadr", {10'd0, v[1]}, {10'd0, V_MEMADR});
        mem_ready = 1'b0;
        step();
        mw_cnt = 0;
        rt_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hs_sw_stall%0d", c), {10'd0, v[1]}, {10'd0, V_MWSTL});
            mw_cnt += int'(memwrite[1]);
            rt_cnt += int'(retire[1]);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("hs_sw_ready", {10'd0, v[1]}, {10'd0, V_MEMWR});
        mw_cnt += int'(memwrite[1]);
        rt_cnt += int'(retire[1]);
        step();
        chk("hs_sw_back_fetch", {10'd0, v[1]}, {10'd0, V_FETCH});
        chk("hs_sw_memwrite_count", mw_cnt, 4);
        chk("hs_sw_retire_count", rt_cnt, 1);

        // ---- bne: legal on default instance, illegal when disabled ----
        opcode = OP_BNE;
        do_reset();
        step();
        chk("nb_bne_decode", {10'd0, v[2]}, {10'd0, V_DECODE});
        step();
        chk("def_bne_ex", {10'd0, v[0]}, {10'd0, V_BNEEX});
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("nb_bne_halt%0d", c), {10'd0, v[2]}, {10'd0, V_HALT});
            step();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("nb_halt_reset_state", {28'd0, st[2]}, 32'd0);
        chk("nb_halt_reset_illegal", {31'd0, illegal[2]}, 32'd0);

        // ---- addi disabled decodes as illegal ----
        opcode = OP_ADDI;
        do_reset();
        step();
        step();
        chk("nb_addi_halt", {10'd0, v[2]}, {10'd0, V_HALT});
        chk("def_addi_ex", {10'd0, v[0]}, {10'd0, V_ADDIEX});

        // ---- Illegal opcode, then asynchronous reset mid-cycle ----
        opcode = OP_BAD;
        do_reset();
        step();
        step();
        chk("bad_halt", {10'd0, v[0]}, {10'd0, V_HALT});
        step();
        chk("bad_halt_held", {10'd0, v[0]}, {10'd0, V_HALT});
        #2;
        rst_n = 1'b0;
        #1;
        chk("bad_async_reset", {10'd0, v[0]}, {10'd0, V_RST});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("bad_first_fetch", {10'd0, v[0]}, {10'd0, V_FETCH});

        // ---- Reset during RTYPEEX: no write-back, clean restart ----
        opcode = OP_R;
        do_reset();
        step();
        step();
        chk("r_rtypeex", {10'd0, v[0]}, {10'd0, V_RTYPE});
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_reset", {10'd0, v[0]}, {10'd0, V_RST});
        step();
        chk("r_no_aluwb", {10'd0, v[0]}, {10'd0, V_RST});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("r_restart_fetch", {10'd0, v[0]}, {10'd0, V_FETCH});
        step();
        chk("r_restart_decode", {10'd0, v[0]}, {10'd0, V_DECODE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 0; 1 = memory states wait for mem_ready, 0 = mem_ready ignored.
REQ-002 SHALL have parameter ENABLE_BNE, default 1; 1 = opcode 000101 (bne) is legal, 0 = it is illegal.
REQ-003 SHALL have parameter ENABLE_ADDI, default 1; 1 = opcode 001000 (addi) is legal, 0 = it is illegal.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-008 SHALL have ports pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal, retire: all outputs, 1 bit each.
REQ-009 SHALL have ports alusrcb, aluop, pcsrc: outputs, 2 bits each.
REQ-010 SHALL have port state, output, 4 bits: current state code (debug).

Function
REQ-011 SHALL be a Moore FSM; every output is a function of state only, except the mem_ready gating in REQ-026.
REQ-012 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ADDIWB=11, JEX=12, HALT=15.
REQ-013 SHALL default every output to 0 in each state unless a requirement below sets it.
REQ-014 FETCH SHALL drive: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
REQ-015 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00; next state by opcode:
- 000000 -> RTYPEEX
- 100011 or 101011 -> MEMADR
- 000100 -> BEQEX
- 000101 -> BNEEX
- 001000 -> ADDIEX
- 000010 -> JEX
- anything else -> HALT
REQ-016 MEMADR SHALL drive alusrca=1, alusrcb=10; next state MEMRD for opcode 100011, MEMWR for opcode 101011.
REQ-017 MEMRD SHALL drive iord=1 and advance to MEMWB.
REQ-018 MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1.
REQ-019 MEMWR SHALL drive iord=1, memwrite=1.
REQ-020 RTYPEEX SHALL drive alusrca=1, alusrcb=00, aluop=10, then go to ALUWB; ALUWB SHALL drive regdst=1, memtoreg=0, regwrite=1.
REQ-021 BEQEX SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; BNEEX SHALL drive the same with branch_ne=1 instead of branch.
REQ-022 ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to ADDIWB; ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1.
REQ-023 JEX SHALL drive pcsrc=10, pcwrite=1.
REQ-024 MEMWB, MEMWR, ALUWB, BEQEX, BNEEX, ADDIWB and JEX SHALL assert retire=1 for that cycle and return to FETCH.
REQ-025 Opcodes 000101 with ENABLE_BNE=0 and 001000 with ENABLE_ADDI=0 SHALL decode as illegal and go to HALT.
REQ-026 With MEM_HANDSHAKE=1:
- FETCH, MEMRD and MEMWR SHALL hold state while mem_ready=0.
- In FETCH, irwrite and pcwrite SHALL assert only in the cycle with mem_ready=1, so the PC increments exactly once.
- In MEMWR, memwrite SHALL stay asserted throughout the stall, and retire SHALL assert only in the mem_ready=1 cycle.
REQ-027 With MEM_HANDSHAKE=0, each state SHALL last exactly one cycle.
REQ-028 HALT SHALL drive illegal=1 and all other outputs 0, and SHALL remain in HALT until reset.
REQ-029 Instruction latency (MEM_HANDSHAKE=0): lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
REQ-030 Any unused state code SHALL transition to HALT.

Reset
REQ-031 rst_n=0 SHALL force state=FETCH immediately (asynchronously), including in the middle of an instruction or from HALT.
REQ-032 While rst_n=0, all outputs SHALL be 0 except the FETCH decode values; irwrite and pcwrite SHALL be gated to 0 during reset.
REQ-033 The first FETCH after rst_n deasserts SHALL be a normal fetch.

Verification
REQ-034 Reset, then lw (100011), MEM_HANDSHAKE=0 -> states 0,1,2,3,4; MEMWB has regwrite=1, memtoreg=1; retire=1 in cycle 5 only.
REQ-035 sw with MEM_HANDSHAKE=1 and mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles; retire pulses once, in the mem_ready=1 cycle.
REQ-036 FETCH with MEM_HANDSHAKE=1 and mem_ready=0 for 2 cycles -> pcwrite=1 and irwrite=1 exactly once, in the 3rd cycle.
REQ-037 bne with ENABLE_BNE=1 -> BNEEX has branch_ne=1, pcsrc=01; with ENABLE_BNE=0 -> DECODE goes to HALT, illegal=1 held until rst_n=0.
REQ-038 Opcode 111111 -> HALT; then rst_n pulsed low mid-cycle -> state=0 immediately, illegal=0.
REQ-039 rst_n asserted during RTYPEEX -> no ALUWB and no regwrite; after reset release the FSM restarts at FETCH.
